pipe_stage_reg: RTL and testbench

//  Generic inter-stage pipeline register, successor to our fixed ID/EX latch, for

---
 rtl/pipe_stage_reg.sv | 84 ++++++++
 tb/tb_pipe_stage_reg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/bubble tracking, a sideband that
// survives bubble insertion, a hold (freeze) input and a saturating bubble counter.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   EMPTY  | no instruction; payload and sideband carry no meaning
//   VALID  | real instruction in the stage
//   BUBBLE | stall bubble; payload zeroed, sideband kept for attribution
//
// Encoding is {valid_out, bubble_out}, so both flags come straight off the state flops.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = 33,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              stall,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [KEEP_W-1:0] keep_in,
    output logic              valid_out,
    output logic              bubble_out,
    output logic [DATA_W-1:0] data_out,
    output logic [KEEP_W-1:0] keep_out,
    output logic [CNT_W-1:0]  bub_cnt
);

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        VALID  = 2'b10,
        BUBBLE = 2'b01
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic [CNT_W-1:0]  r_bub_cnt;
    logic              w_cnt_sat;

    // Counter is saturated once every bit is set; it must never wrap.
    assign w_cnt_sat = &r_bub_cnt;

    // Stage update, priority reset > flush > hold > stall > advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= EMPTY;
            r_data    <= '0;
            r_keep    <= '0;
            r_bub_cnt <= '0;
        end else if (flush) begin
            // Exception kill: clears sideband too, but bubble history is kept.
            r_state <= EMPTY;
            r_data  <= '0;
            r_keep  <= '0;
        end else if (hold) begin
            r_state   <= r_state;
            r_data    <= r_data;
            r_keep    <= r_keep;
            r_bub_cnt <= r_bub_cnt;
        end else if (stall) begin
            r_state <= BUBBLE;
            r_data  <= '0;
            r_keep  <= keep_in;
            if (!w_cnt_sat) begin
                r_bub_cnt <= r_bub_cnt + CNT_W'(1);
            end
        end else begin
            // Payload and sideband load even for a non-valid entry.
            r_state <= valid_in ? VALID : EMPTY;
            r_data  <= data_in;
            r_keep  <= keep_in;
        end
    end

    assign valid_out  = r_state[1];
    assign bubble_out = r_state[0];
    assign data_out   = r_data;
    assign keep_out   = r_keep;
    assign bub_cnt    = r_bub_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default-width instance for the main
// behaviour, plus a CNT_W=2 instance for counter saturation.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (default parameters)
    logic        reset, flush, hold, stall, valid_in;
    logic [63:0] data_in;
    logic [32:0] keep_in;
    logic        valid_out, bubble_out;
    logic [63:0] data_out;
    logic [32:0] keep_out;
    logic [15:0] bub_cnt;

    // Small-counter instance
    logic        s_reset, s_flush, s_hold, s_stall, s_valid_in;
    logic [63:0] s_data_in;
    logic [32:0] s_keep_in;
    logic        s_valid_out, s_bubble_out;
    logic [63:0] s_data_out;
    logic [32:0] s_keep_out;
    logic [1:0]  s_bub_cnt;

    int checks = 0;
    int failures = 0;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .flush(flush), .hold(hold), .stall(stall),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
        .valid_out(valid_out), .bubble_out(bubble_out), .data_out(data_out),
        .keep_out(keep_out), .bub_cnt(bub_cnt)
    );

    pipe_stage_reg #(.DATA_W(64), .KEEP_W(33), .CNT_W(2)) dut_s (
        .clk(clk), .reset(s_reset), .flush(s_flush), .hold(s_hold), .stall(s_stall),
        .valid_in(s_valid_in), .data_in(s_data_in), .keep_in(s_keep_in),
        .valid_out(s_valid_out), .bubble_out(s_bubble_out), .data_out(s_data_out),
        .keep_out(s_keep_out), .bub_cnt(s_bub_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1; flush = 0; hold = 0; stall = 0; valid_in = 1;
        data_in = '1; keep_in = '1;
        s_reset = 1; s_flush = 0; s_hold = 0; s_stall = 0; s_valid_in = 0;
        s_data_in = '0; s_keep_in = '0;
        step();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
        checks++; if (bubble_out !== 1'b0) begin failures++; $display("FAIL rst_bubble got=%b exp=0", bubble_out); end
        checks++; if (data_out !== 64'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", data_out); end
        checks++; if (keep_out !== 33'h0) begin failures++; $display("FAIL rst_keep got=%h exp=0", keep_out); end
        checks++; if (bub_cnt !== 16'h0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", bub_cnt); end
        checks++; if (s_bub_cnt !== 2'd0) begin failures++; $display("FAIL rst_scnt got=%0d exp=0", s_bub_cnt); end
        reset = 0; s_reset = 0;
    endtask

    task automatic test_advance();
        valid_in = 1; data_in = 64'h1234; keep_in = {1'b0, 32'h3000};
        step();
        checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL adv_valid got=%b exp=1", valid_out); end
        checks++; if (bubble_out !== 1'b0) begin failures++; $display("FAIL adv_bubble got=%b exp=0", bubble_out); end
        checks++; if (data_out !== 64'h1234) begin failures++; $display("FAIL adv_data got=%h exp=1234", data_out); end
        checks++; if (keep_out !== 33'h0_0000_3000) begin failures++; $display("FAIL adv_keep got=%h exp=000003000", keep_out); end
        checks++; if (bub_cnt !== 16'd0) begin failures++; $display("FAIL adv_cnt got=%0d exp=0", bub_cnt); end
    endtask

    task automatic test_stall();
        stall = 1; data_in = 64'hDEAD_BEEF; keep_in = {1'b1, 32'h3004};
        step();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL stall_valid got=%b exp=0", valid_out); end
        checks++; if (bubble_out !== 1'b1) begin failures++; $display("FAIL stall_bubble got=%b exp=1", bubble_out); end
        checks++; if (data_out !== 64'h0) begin failures++; $display("FAIL stall_data got=%h exp=0", data_out); end
        checks++; if (keep_out !== 33'h1_0000_3004) begin failures++; $display("FAIL stall_keep got=%h exp=100003004", keep_out); end
        checks++; if (bub_cnt !== 16'd1) begin failures++; $display("FAIL stall_cnt got=%0d exp=1", bub_cnt); end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 3; i++) begin
            hold = 1; stall = 1; valid_in = 1;
            data_in = 64'hA000 + 64'(i); keep_in = 33'h0_0000_4000 + 33'(i);
            step();
            checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL hold%0d_valid got=%b exp=0", i, valid_out); end
            checks++; if (bubble_out !== 1'b1) begin failures++; $display("FAIL hold%0d_bubble got=%b exp=1", i, bubble_out); end
            checks++; if (data_out !== 64'h0) begin failures++; $display("FAIL hold%0d_data got=%h exp=0", i, data_out); end
            checks++; if (keep_out !== 33'h1_0000_3004) begin failures++; $display("FAIL hold%0d_keep got=%h exp=100003004", i, keep_out); end
            checks++; if (bub_cnt !== 16'd1) begin failures++; $display("FAIL hold%0d_cnt got=%0d exp=1", i, bub_cnt); end
        end
    endtask

    task automatic test_flush_all();
        flush = 1; hold = 1; stall = 1;
        step();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", valid_out); end
        checks++; if (bubble_out !== 1'b0) begin failures++; $display("FAIL flush_bubble got=%b exp=0", bubble_out); end
        checks++; if (data_out !== 64'h0) begin failures++; $display("FAIL flush_data got=%h exp=0", data_out); end
        checks++; if (keep_out !== 33'h0) begin failures++; $display("FAIL flush_keep got=%h exp=0", keep_out); end
        checks++; if (bub_cnt !== 16'd1) begin failures++; $display("FAIL flush_cnt got=%0d exp=1", bub_cnt); end
        flush = 0; hold = 0; stall = 0;
    endtask

    task automatic test_advance_invalid();
        valid_in = 0; data_in = 64'h55; keep_in = 33'h7;
        step();
        checks++; if ({valid_out, bubble_out} !== 2'b00) begin failures++; $display("FAIL inv_state got=%b exp=00", {valid_out, bubble_out}); end
        checks++; if (data_out !== 64'h55) begin failures++; $display("FAIL inv_data got=%h exp=55", data_out); end
        checks++; if (keep_out !== 33'h7) begin failures++; $display("FAIL inv_keep got=%h exp=7", keep_out); end
    endtask

    task automatic test_hold_valid();
        valid_in = 1; data_in = 64'hCAFE_0001; keep_in = 33'h0_0000_5000;
        step();
        hold = 1; valid_in = 0; data_in = 64'h9999; keep_in = 33'h1_FFFF_FFFF;
        step();
        step();
        checks++; if ({valid_out, bubble_out} !== 2'b10) begin failures++; $display("FAIL holdv_state got=%b exp=10", {valid_out, bubble_out}); end
        checks++; if (data_out !== 64'hCAFE_0001) begin failures++; $display("FAIL holdv_data got=%h exp=cafe0001", data_out); end
        checks++; if (keep_out !== 33'h0_0000_5000) begin failures++; $display("FAIL holdv_keep got=%h exp=000005000", keep_out); end
        hold = 0; flush = 1;
        step();
        checks++; if ({valid_out, bubble_out} !== 2'b00) begin failures++; $display("FAIL flushv_state got=%b exp=00", {valid_out, bubble_out}); end
        checks++; if (keep_out !== 33'h0) begin failures++; $display("FAIL flushv_keep got=%h exp=0", keep_out); end
        flush = 0;
    endtask

    task automatic test_back_to_back();
        stall = 1; keep_in = 33'h0_0000_6000;
        step();
        checks++; if (bub_cnt !== 16'd2) begin failures++; $display("FAIL b2b1_cnt got=%0d exp=2", bub_cnt); end
        keep_in = 33'h1_0000_6004;
        step();
        checks++; if (bub_cnt !== 16'd3) begin failures++; $display("FAIL b2b2_cnt got=%0d exp=3", bub_cnt); end
        checks++; if (keep_out !== 33'h1_0000_6004) begin failures++; $display("FAIL b2b2_keep got=%h exp=100006004", keep_out); end
        checks++; if ({valid_out, bubble_out} !== 2'b01) begin failures++; $display("FAIL b2b2_state got=%b exp=01", {valid_out, bubble_out}); end
        stall = 0; valid_in = 1; data_in = 64'h77; keep_in = 33'h8;
        step();
        checks++; if ({valid_out, bubble_out} !== 2'b10) begin failures++; $display("FAIL b2b3_state got=%b exp=10", {valid_out, bubble_out}); end
        checks++; if (data_out !== 64'h77) begin failures++; $display("FAIL b2b3_data got=%h exp=77", data_out); end
    endtask

    task automatic test_reset_mid();
        reset = 1; flush = 1; hold = 1; stall = 1; valid_in = 1;
        data_in = '1; keep_in = '1;
        step();
        checks++; if ({valid_out, bubble_out} !== 2'b00) begin failures++; $display("FAIL rstmid_state got=%b exp=00", {valid_out, bubble_out}); end
        checks++; if (data_out !== 64'h0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", data_out); end
        checks++; if (keep_out !== 33'h0) begin failures++; $display("FAIL rstmid_keep got=%h exp=0", keep_out); end
        checks++; if (bub_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", bub_cnt); end
        reset = 0; flush = 0; hold = 0; stall = 0; valid_in = 0;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        for (int i = 0; i < 5; i++) begin
            s_stall = 1; s_keep_in = 33'(i);
            step();
            checks++; if (s_bub_cnt !== exp_cnt[i]) begin failures++; $display("FAIL sat%0d_cnt got=%0d exp=%0d", i, s_bub_cnt, exp_cnt[i]); end
        end
        checks++; if (s_bubble_out !== 1'b1) begin failures++; $display("FAIL sat_bubble got=%b exp=1", s_bubble_out); end
        s_reset = 1;
        step();
        checks++; if (s_bub_cnt !== 2'd0) begin failures++; $display("FAIL satrst_cnt got=%0d exp=0", s_bub_cnt); end
        checks++; if (s_bubble_out !== 1'b0) begin failures++; $display("FAIL satrst_bubble got=%b exp=0", s_bubble_out); end
        s_reset = 0; s_stall = 0;
    endtask

    initial begin
        test_reset();
        test_advance();
        test_stall();
        test_hold_stall();
        test_flush_all();
        test_advance_invalid();
        test_hold_valid();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
